// File: rtl/cdc_fifo_write_frontend.sv
// Write-domain front end of the CDC FIFO: 2-entry skid buffer feeding the RAM write port,
// plus the read-pointer synchroniser. Optional almost_full via CDC_FIFO_WRITE_FRONTEND_ALMOST_FULL_EN.
//
// Handshake: a beat transfers on a rising clock edge where in_valid=1 and in_ready=1;
// in_ready is a register and never looks at in_valid or full in the same cycle.
module cdc_fifo_write_frontend #(
  parameter int ADDRESS_WIDTH     = 4,
  parameter int DATA_WIDTH        = 8,
  parameter int SYNC_STAGES       = 2,
  parameter int ALMOST_FULL_LEVEL = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     in_ready,
  input  logic                     full,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic [ADDRESS_WIDTH-1:0] read_address_gray_async,
  output logic [ADDRESS_WIDTH-1:0] read_address_gray_sync,
  output logic                     increment,
  output logic                     mem_write_enable,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
`ifdef CDC_FIFO_WRITE_FRONTEND_ALMOST_FULL_EN
  output logic                     almost_full,
`endif
  output logic [1:0]               debug_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   head_q, head_d;
  logic [DATA_WIDTH-1:0]   skid_q, skid_d;
  logic                    in_ready_q, in_ready_d;
  logic [ADDRESS_WIDTH-1:0] sync_q [SYNC_STAGES];

  logic accept;
  logic drain;

  // Plain flop chain; gray coding guarantees at most one bit is in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= read_address_gray_async;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign read_address_gray_sync = sync_q[SYNC_STAGES-1];

  assign accept = in_valid & in_ready_q;
  assign drain  = (state_q != ST_EMPTY) & ~full;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          head_d  = in_data;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          head_d = in_data;
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = in_data;
        end else if (drain) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d = ST_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // RAM capture and pointer advance happen on the same edge, so both strobes are drain.
  assign in_ready          = in_ready_q;
  assign increment         = drain;
  assign mem_write_enable  = drain;
  assign mem_write_address = write_address;
  assign mem_write_data    = head_q;
  assign debug_state       = state_q;

`ifdef CDC_FIFO_WRITE_FRONTEND_ALMOST_FULL_EN
  localparam logic [ADDRESS_WIDTH-1:0] AF_LEVEL = ALMOST_FULL_LEVEL[ADDRESS_WIDTH-1:0];

  logic [ADDRESS_WIDTH-1:0] read_binary;
  logic [ADDRESS_WIDTH-1:0] occupancy;
  logic                     almost_full_q, almost_full_d;

  // Stale read pointer makes occupancy an over-estimate, which is the safe direction.
  always_comb begin
    read_binary = '0;
    for (int i = 0; i < ADDRESS_WIDTH; i++) read_binary[i] = ^(read_address_gray_sync >> i);
    occupancy     = write_address - read_binary;
    almost_full_d = (occupancy >= AF_LEVEL);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) almost_full_q <= 1'b0;
    else       almost_full_q <= almost_full_d;
  end

  assign almost_full = almost_full_q;
`endif

endmodule

// File: tb/tb_cdc_fifo_write_frontend.sv
// Bench for cdc_fifo_write_frontend: stub write pointer, write scoreboard, vector table
// for the backpressure sequence and hand-written sequences for the remaining corners.
module tb_cdc_fifo_write_frontend;

  localparam int AW   = 4;
  localparam int DW   = 8;
  localparam int SYNC = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          full = 1'b0;
  logic [AW-1:0] write_address;
  logic [AW-1:0] read_address_gray_async = '0;
  logic [AW-1:0] read_address_gray_sync;
  logic          increment;
  logic          mem_write_enable;
  logic [AW-1:0] mem_write_address;
  logic [DW-1:0] mem_write_data;
  logic [1:0]    debug_state;
`ifdef CDC_FIFO_WRITE_FRONTEND_ALMOST_FULL_EN
  logic          almost_full;
`endif

  logic [AW-1:0] wa_stub;
  logic          wa_force_en = 1'b0;
  logic [AW-1:0] wa_force = '0;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int inc_count = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_q[$];

  cdc_fifo_write_frontend #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .ALMOST_FULL_LEVEL(12)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .full(full), .write_address(write_address),
    .read_address_gray_async(read_address_gray_async),
    .read_address_gray_sync(read_address_gray_sync), .increment(increment),
    .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
`ifdef CDC_FIFO_WRITE_FRONTEND_ALMOST_FULL_EN
    .almost_full(almost_full),
`endif
    .debug_state(debug_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Stand-in for the write state block's binary pointer.
  always @(posedge clock or posedge reset) begin
    if (reset) wa_stub <= '0;
    else if (increment) wa_stub <= wa_stub + 1'b1;
  end
  assign write_address = wa_force_en ? wa_force : wa_stub;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: pop on write before pushing this cycle's accept, so a same-cycle bypass is caught.
  always @(negedge clock) begin
    if (!reset) begin
      check("increment_eq_we", {31'd0, increment}, {31'd0, mem_write_enable});
      if (increment) inc_count++;
      if (mem_write_enable) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          check("write_unexpected", {24'd0, mem_write_data}, 32'hFFFF_FFFF);
        end else begin
          check("write_data", {24'd0, mem_write_data}, {24'd0, exp_q.pop_front()});
        end
        check("write_addr", {28'd0, mem_write_address}, {28'd0, exp_addr});
        exp_addr = exp_addr + 1'b1;
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic          in_valid;
    logic          full;
    logic [DW-1:0] in_data;
    logic          exp_ready;
    logic          exp_we;
    logic [1:0]    exp_state;
  } vec_t;

  vec_t bp_vec[7];

  initial begin
    int cyc;
    int idx;
    int wr_base;
    int inc_base;
    int lat;

    bp_vec[0] = '{1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, 2'd0};
    bp_vec[1] = '{1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 2'd1};
    bp_vec[2] = '{1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 2'd2};
    bp_vec[3] = '{1'b1, 1'b0, 8'hA2, 1'b0, 1'b1, 2'd2};
    bp_vec[4] = '{1'b1, 1'b0, 8'hA2, 1'b1, 1'b1, 2'd1};
    bp_vec[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 2'd1};
    bp_vec[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0};

    // reset state
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_we", {31'd0, mem_write_enable}, 32'd0);
    check("rst_inc", {31'd0, increment}, 32'd0);
    check("rst_sync", {28'd0, read_address_gray_sync}, 32'd0);
    check("rst_state", {30'd0, debug_state}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    next_cycle();

    // streaming: one beat per clock, written the cycle after acceptance
    for (int i = 0; i <= 16; i++) begin
      in_valid = (i < 16);
      in_data  = 8'(i + 1);
      full     = 1'b0;
      @(negedge clock);
      check("stream_we", {31'd0, mem_write_enable}, {31'd0, (i >= 1)});
      check("stream_ready", {31'd0, in_ready}, 32'd1);
      next_cycle();
    end
    in_valid = 1'b0;
    check("stream_count", wr_count, 32'd16);

    // backpressure table
    for (int i = 0; i < 7; i++) begin
      in_valid = bp_vec[i].in_valid;
      full     = bp_vec[i].full;
      in_data  = bp_vec[i].in_data;
      @(negedge clock);
      check($sformatf("bp%0d_ready", i), {31'd0, in_ready}, {31'd0, bp_vec[i].exp_ready});
      check($sformatf("bp%0d_we", i), {31'd0, mem_write_enable}, {31'd0, bp_vec[i].exp_we});
      check($sformatf("bp%0d_state", i), {30'd0, debug_state}, {30'd0, bp_vec[i].exp_state});
      next_cycle();
    end
    check("bp_count", wr_count, 32'd19);

    // full toggling every cycle, 20 beats
    wr_base  = wr_count;
    inc_base = inc_count;
    idx = 0;
    cyc = 0;
    in_valid = 1'b1;
    in_data  = 8'h40;
    full     = 1'b0;
    while ((wr_count - wr_base) < 20 && cyc < 300) begin
      @(negedge clock);
      if (in_valid && in_ready) idx++;
      next_cycle();
      full     = ~full;
      in_valid = (idx < 20);
      in_data  = (idx < 20) ? 8'(8'h40 + idx) : 8'h00;
      cyc++;
    end
    in_valid = 1'b0;
    full     = 1'b0;
    repeat (3) next_cycle();
    check("toggle_timeout", {31'd0, (cyc >= 300)}, 32'd0);
    check("toggle_writes", wr_count - wr_base, 32'd20);
    check("toggle_incs", inc_count - inc_base, 32'd20);
    check("toggle_q_empty", exp_q.size(), 32'd0);

    // synchroniser latency
    for (int s = 0; s < 2; s++) begin
      read_address_gray_async = (s == 0) ? 4'b0001 : 4'b0011;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
        @(posedge clock);
        @(negedge clock);
        if (read_address_gray_sync == read_address_gray_async) begin
          lat = k;
          break;
        end
      end
      check($sformatf("sync_latency%0d", s), lat, SYNC);
      next_cycle();
    end

`ifdef CDC_FIFO_WRITE_FRONTEND_ALMOST_FULL_EN
    read_address_gray_async = 4'b0000;
    repeat (SYNC + 2) next_cycle();
    wa_force_en = 1'b1;
    wa_force    = 4'd12;
    next_cycle();
    check("af_set", {31'd0, almost_full}, 32'd1);
    read_address_gray_async = 4'b0010;
    repeat (SYNC) next_cycle();
    check("af_hold", {31'd0, almost_full}, 32'd1);
    next_cycle();
    check("af_clear", {31'd0, almost_full}, 32'd0);
    wa_force_en = 1'b0;
`endif

    // reset mid-burst with two beats buffered
    full = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h77;
    next_cycle();
    in_data = 8'h78;
    next_cycle();
    in_valid = 1'b0;
    check("pre_rst_state", {30'd0, debug_state}, 32'd2);
    check("pre_rst_ready", {31'd0, in_ready}, 32'd0);
    full = 1'b0;
    #1;
    check("pre_rst_we", {31'd0, mem_write_enable}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_we", {31'd0, mem_write_enable}, 32'd0);
    check("mid_rst_inc", {31'd0, increment}, 32'd0);
    check("mid_rst_sync", {28'd0, read_address_gray_sync}, 32'd0);
    check("mid_rst_state", {30'd0, debug_state}, 32'd0);
`ifdef CDC_FIFO_WRITE_FRONTEND_ALMOST_FULL_EN
    check("mid_rst_af", {31'd0, almost_full}, 32'd0);
`endif
    exp_q.delete();
    exp_addr = '0;
    @(negedge clock);
    reset = 1'b0;
    read_address_gray_async = 4'b0000;
    next_cycle();

    // one beat after reset: discarded beats must not reappear
    wr_base = wr_count;
    in_valid = 1'b1;
    in_data  = 8'h55;
    next_cycle();
    in_valid = 1'b0;
    repeat (3) next_cycle();
    check("post_rst_writes", wr_count - wr_base, 32'd1);
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
